// File: rtl/vending_pkg.sv
// Shared definitions for the coin acceptor and the vending FSM it feeds:
// output FSM state encoding, coin-type codes and coin queue geometry.
package vending_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } vend_state_e;

    typedef enum logic {
        COIN_A = 1'b0,
        COIN_B = 1'b1
    } coin_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchronizer, debounce counter and a one-cycle
// event pulse when the debounced level rises.
module coin_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sens,
    output logic rise
);
    localparam int unsigned CW = 4;

    logic             s1;
    logic             s2;
    logic             level;
    logic [CW-1:0]    cnt;

    // level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= sens;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 != level) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    level <= s2;
                    cnt   <= '0;
                    rise  <= s2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces two coin sensors, queues coin types in a 4-deep
// FIFO and replays them as spaced one-cycle i/j pulses for the vending FSM.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned GAP        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sens_a,
    input  logic             sens_b,
    output logic             i,
    output logic             j,
    output logic             reject,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    localparam int unsigned GAP_W = 3;

    vend_state_e      state_q;
    vend_state_e      state_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    coin_e            mem [FIFO_DEPTH];
    coin_e            head_c;
    logic             rise_a;
    logic             rise_b;
    logic             single_c;
    logic             pop_c;
    logic             push_c;
    logic             refuse_c;
    logic             i_d;
    logic             j_d;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk  (clk),
        .rst  (rst),
        .sens (sens_a),
        .rise (rise_a)
    );

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk  (clk),
        .rst  (rst),
        .sens (sens_b),
        .rise (rise_b)
    );

    // simultaneous events are a jam; a full queue may still accept if it pops
    assign single_c = rise_a ^ rise_b;
    assign push_c   = single_c & (~full | pop_c);
    assign refuse_c = (rise_a & rise_b) | (single_c & full & ~pop_c);
    assign head_c   = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push_c && !pop_c) begin
            count_d = count + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count - CNT_W'(1);
        end
    end

    // output sequencer: pop in IDLE, pulse in EMIT, rest GAP cycles in HOLD
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop_c   = 1'b0;
        i_d     = 1'b0;
        j_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop_c   = 1'b1;
                    state_d = EMIT;
                    i_d     = (head_c == COIN_A);
                    j_d     = (head_c == COIN_B);
                end
            end
            EMIT: begin
                state_d = HOLD;
                gap_d   = '0;
            end
            HOLD: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            i       <= 1'b0;
            j       <= 1'b0;
            reject  <= 1'b0;
            count   <= '0;
            full    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            i       <= i_d;
            j       <= j_d;
            reject  <= refuse_c;
            count   <= count_d;
            full    <= (count_d == CNT_W'(FIFO_DEPTH));
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // queue storage needs no reset: only slots below count are ever read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= coin_e'(rise_b);
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: two configurations share the sensor
// stimulus; a cycle-level reference model predicts pulses, rejects and count.
module tb_coin_acceptor;

    localparam int NI   = 2;
    localparam int DEB0 = 4;
    localparam int GAP0 = 2;
    localparam int DEB1 = 2;
    localparam int GAP1 = 7;

    typedef struct {
        int at;
        bit typ;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sens_a = 1'b0;
    logic       sens_b = 1'b0;
    logic       i_o    [NI];
    logic       j_o    [NI];
    logic       rej_o  [NI];
    logic       full_o [NI];
    logic [2:0] cnt_o  [NI];

    exp_t pq [NI][$];
    int   rq [NI][$];
    bit   mf [NI][$];
    int   next_pop [NI];
    bit   d1  [NI][2];
    bit   d2  [NI][2];
    bit   lvl [NI][2];
    bit   evp [NI][2];
    int   run [NI][2];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int last_pulse [NI];
    int rej_seen [NI];
    int max_cnt [NI];
    int pe0 [$];
    bit pt0 [$];

    coin_acceptor #(.DEB_CYCLES(DEB0), .GAP(GAP0)) u_dut0 (
        .clk(clk), .rst(rst), .sens_a(sens_a), .sens_b(sens_b),
        .i(i_o[0]), .j(j_o[0]), .reject(rej_o[0]), .count(cnt_o[0]), .full(full_o[0])
    );

    coin_acceptor #(.DEB_CYCLES(DEB1), .GAP(GAP1)) u_dut1 (
        .clk(clk), .rst(rst), .sens_a(sens_a), .sens_b(sens_b),
        .i(i_o[1]), .j(j_o[1]), .reject(rej_o[1]), .count(cnt_o[1]), .full(full_o[1])
    );

    always #5 clk = ~clk;

    function automatic int deb_of(input int n);
        return (n == 0) ? DEB0 : DEB1;
    endfunction

    function automatic int gap_of(input int n);
        return (n == 0) ? GAP0 : GAP1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic model_reset(input int n);
        mf[n].delete();
        pq[n].delete();
        rq[n].delete();
        next_pop[n] = 0;
        for (int s = 0; s < 2; s++) begin
            d1[n][s]  = 1'b0;
            d2[n][s]  = 1'b0;
            lvl[n][s] = 1'b0;
            evp[n][s] = 1'b0;
            run[n][s] = 0;
        end
    endtask

    // one clock edge of the reference: drain, then queue last edge's events,
    // then advance sensor filtering
    task automatic model_step(input int n);
        bit sv [2];
        bit y;
        bit t;
        bit pop;
        sv[0] = sens_a;
        sv[1] = sens_b;
        pop = (mf[n].size() > 0) && (cyc >= next_pop[n]);
        if (pop) begin
            t = mf[n].pop_front();
            pq[n].push_back('{at: cyc + 1, typ: t});
            next_pop[n] = cyc + gap_of(n) + 2;
        end
        if (evp[n][0] && evp[n][1]) begin
            rq[n].push_back(cyc + 1);
        end else if (evp[n][0] || evp[n][1]) begin
            if (mf[n].size() < 4) mf[n].push_back(evp[n][1]);
            else rq[n].push_back(cyc + 1);
        end
        for (int s = 0; s < 2; s++) begin
            y = d2[n][s];
            d2[n][s] = d1[n][s];
            d1[n][s] = sv[s];
            evp[n][s] = 1'b0;
            if (y != lvl[n][s]) begin
                run[n][s]++;
                if (run[n][s] == deb_of(n)) begin
                    lvl[n][s] = y;
                    run[n][s] = 0;
                    evp[n][s] = y;
                end
            end else begin
                run[n][s] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int n = 0; n < NI; n++) begin
            if (rst) model_reset(n);
            else model_step(n);
        end
    end

    // monitor: consumer view of each output, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        int   r;
        for (int n = 0; n < NI; n++) begin
            if (rst) begin
                pq[n].delete();
                rq[n].delete();
                chk($sformatf("reset_outputs%0d", n),
                    int'({i_o[n], j_o[n], rej_o[n], full_o[n], cnt_o[n]}), 0);
            end else begin
                if (i_o[n] || j_o[n]) begin
                    chk($sformatf("i_and_j%0d", n), int'(i_o[n] & j_o[n]), 0);
                    if (pq[n].size() == 0) begin
                        chk($sformatf("spurious_pulse%0d", n), int'(i_o[n] | j_o[n]), 0);
                    end else begin
                        e = pq[n].pop_front();
                        chk($sformatf("pulse_edge%0d", n), cyc + 1, e.at);
                        chk($sformatf("pulse_type%0d", n), int'(j_o[n]), int'(e.typ));
                        last_pulse[n] = cyc + 1;
                        if (n == 0) begin
                            pe0.push_back(cyc + 1);
                            pt0.push_back(j_o[n]);
                        end
                    end
                end else if (pq[n].size() > 0 && pq[n][0].at <= cyc + 1) begin
                    e = pq[n].pop_front();
                    chk($sformatf("missing_pulse%0d", n), int'(i_o[n] | j_o[n]), 1);
                end
                if (rej_o[n]) begin
                    rej_seen[n]++;
                    if (rq[n].size() == 0) begin
                        chk($sformatf("spurious_reject%0d", n), int'(rej_o[n]), 0);
                    end else begin
                        r = rq[n].pop_front();
                        chk($sformatf("reject_edge%0d", n), cyc + 1, r);
                    end
                end else if (rq[n].size() > 0 && rq[n][0] <= cyc + 1) begin
                    r = rq[n].pop_front();
                    chk($sformatf("missing_reject%0d", n), int'(rej_o[n]), 1);
                end
                chk($sformatf("count%0d", n), int'(cnt_o[n]), mf[n].size());
                chk($sformatf("full%0d", n), int'(full_o[n]), int'(mf[n].size() == 4));
                if (int'(cnt_o[n]) > max_cnt[n]) max_cnt[n] = int'(cnt_o[n]);
            end
        end
    end

    task automatic wait_pulse(input int n, input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            step(1);
            if (i_o[n] || j_o[n]) seen = 1'b1;
        end
    endtask

    initial begin
        int e0;
        int r0;
        bit seen;
        for (int n = 0; n < NI; n++) begin
            last_pulse[n] = -1;
            rej_seen[n]   = 0;
            max_cnt[n]    = 0;
        end
        step(3);
        rst = 1'b0;
        step(3);

        // single coin A, held 10 cycles
        sens_a = 1'b1;
        e0 = cyc + 1;
        step(10);
        sens_a = 1'b0;
        step(16);
        chk("latency_a0", last_pulse[0], e0 + 2 + DEB0 + 2);
        chk("latency_a1", last_pulse[1], e0 + 2 + DEB1 + 2);

        // bouncing contact before a stable high
        for (int k = 0; k < 6; k++) begin
            sens_a = (k % 2 == 0);
            step(1);
        end
        sens_a = 1'b1;
        e0 = cyc + 1;
        step(10);
        sens_a = 1'b0;
        step(16);
        chk("latency_bounce0", last_pulse[0], e0 + 2 + DEB0 + 2);

        // jam: both sensors rise on the same edge
        r0 = rej_seen[0];
        sens_a = 1'b1;
        sens_b = 1'b1;
        step(10);
        sens_a = 1'b0;
        sens_b = 1'b0;
        step(16);
        chk("jam_rejects0", rej_seen[0] - r0, 1);

        // A, B, A arriving close enough to stay queued back-to-back
        pe0.delete();
        pt0.delete();
        sens_a = 1'b1;
        step(1);
        sens_b = 1'b1;
        step(3);
        sens_a = 1'b0;
        step(4);
        sens_a = 1'b1;
        step(6);
        sens_a = 1'b0;
        sens_b = 1'b0;
        step(30);
        chk("aba_pulses", pe0.size(), 3);
        if (pe0.size() == 3) begin
            chk("aba_gap1", pe0[1] - pe0[0], GAP0 + 2);
            chk("aba_gap2", pe0[2] - pe0[1], GAP0 + 2);
            chk("aba_types", int'({pt0[0], pt0[1], pt0[2]}), 3'b010);
        end

        // random sensor activity
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(5, 0) == 0) sens_a = ~sens_a;
            if ($urandom_range(5, 0) == 0) sens_b = ~sens_b;
            step(1);
        end
        sens_a = 1'b0;
        sens_b = 1'b0;
        step(60);

        // overflow: coins faster than the slow configuration drains them
        max_cnt[1] = 0;
        r0 = rej_seen[1];
        for (int k = 0; k < 8; k++) begin
            sens_a = 1'b1;
            sens_b = 1'b0;
            step(3);
            sens_a = 1'b0;
            sens_b = 1'b1;
            step(3);
        end
        sens_b = 1'b0;
        chk("ovf_max_count1", max_cnt[1], 4);
        chk("ovf_rejected1", int'(rej_seen[1] > r0), 1);

        // reset while a pulse is on the output with coins still queued
        wait_pulse(1, 100, seen);
        chk("emit_before_reset", int'(seen), 1);
        rst = 1'b1;
        #1;
        chk("reset_kills_pulse", int'(i_o[1] | j_o[1] | i_o[0] | j_o[0]), 0);
        step(3);
        rst = 1'b0;
        step(40);

        // sensor still high across reset release counts as a fresh coin
        sens_a = 1'b1;
        step(2);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        e0 = cyc + 1;
        step(20);
        sens_a = 1'b0;
        step(40);
        chk("post_reset_coin0", last_pulse[0], e0 + 2 + DEB0 + 2);

        for (int n = 0; n < NI; n++) begin
            chk($sformatf("pending_pulses%0d", n), pq[n].size(), 0);
            chk($sformatf("pending_rejects%0d", n), rq[n].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, consecutive stable samples required to accept a sensor level change (range 2..15).
REQ-002 SHALL have parameter GAP, default 2, idle cycles forced after each output pulse (range 1..7).
REQ-003 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sens_a, input, 1, raw asynchronous coin-A sensor, high while a coin passes.
REQ-006 SHALL have port sens_b, input, 1, raw asynchronous coin-B sensor, high while a coin passes.
REQ-007 SHALL have port i, output, 1, one-cycle coin-A pulse to the vending FSM input i.
REQ-008 SHALL have port j, output, 1, one-cycle coin-B pulse to the vending FSM input j.
REQ-009 SHALL have port reject, output, 1, one-cycle pulse when a coin is refused (jam or overflow).
REQ-010 SHALL have port count, output, 3, current queue occupancy 0..4.
REQ-011 SHALL have port full, output, 1, high when count == 4.

Function
REQ-012 SHALL pass each sensor through a 2-flop synchronizer before any other logic.
REQ-013 SHALL keep one debounced level per sensor, changed only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free sample restarts the counter.
REQ-014 SHALL generate a coin event for a sensor in the cycle its debounced level goes 0->1; the 1->0 transition generates nothing.
REQ-015 SHALL treat coin-A and coin-B events in the same cycle as a jam: reject pulses, nothing queued.
REQ-016 SHALL queue each single coin event as a 1-bit type (0=A, 1=B) into a 4-entry FIFO, in arrival order.
REQ-017 SHALL refuse an event arriving while full with no pop that cycle: reject pulses, event dropped, FIFO unchanged.
REQ-018 SHALL accept a push while full when a pop occurs in the same cycle; count stays 4.
REQ-019 SHALL run an output FSM with states IDLE, EMIT, HOLD.
REQ-020 IDLE: if FIFO non-empty, pop head and go to EMIT next cycle; else stay.
REQ-021 EMIT: drive i=1 (type A) or j=1 (type B) for exactly one cycle, then go to HOLD.
REQ-022 HOLD: drive i=j=0 for GAP cycles, then return to IDLE.
REQ-023 SHALL never assert i and j together; outside EMIT both are 0.
REQ-024 SHALL produce, with empty FIFO and FSM in IDLE, i/j high 2+DEB_CYCLES+2 clocks after the first clock edge sampling the sensor high.
REQ-025 SHALL wrap FIFO read/write pointers modulo 4; count updates in the cycle after the push/pop.

Reset
REQ-026 SHALL on rst asynchronously clear synchronizers, debounced levels, debounce counters, FIFO pointers and count, and force FSM to IDLE.
REQ-027 SHALL hold i=0, j=0, reject=0, count=0, full=0 while rst is high.
REQ-028 SHALL discard queued coins and any pulse in progress on mid-operation reset; a sensor still high at release counts as a new coin only after a full debounce.

Structure
REQ-029 SHALL place FSM state encoding (IDLE, EMIT, HOLD), coin-type codes and FIFO depth 4 in shared package vending_pkg, reused by the vending FSM.
REQ-030 SHALL instantiate one sub-module coin_debounce (synchronizer + counter + rising-event), once per sensor.

Verification
REQ-031 Single A: sens_a high 10 cycles, DEB_CYCLES=4 -> exactly one i pulse 8 clocks after first sample, j=0, reject=0.
REQ-032 Bounce: sens_a toggles every cycle 6 times, then high 10 cycles -> exactly one i pulse, timed from start of stable high.
REQ-033 Jam: sens_a and sens_b rise on the same edge, held 10 cycles -> one reject pulse, no i/j, count=0.
REQ-034 Ordering and gap: coins A,B,A queued back-to-back, GAP=2 -> i, j, i pulses each separated by exactly 3 low cycles.
REQ-035 Overflow: 6 coins arrive faster than drained with FSM in HOLD -> full=1, count=4, reject per refused coin, first 4 emitted in order.
REQ-036 Reset mid-EMIT with count=3 -> i=j=0 immediately, count=0, no further pulses after release.
